// File: rtl/lowampa_capture_pkg.sv
// lowampa_capture_pkg: shared state encoding and default widths for the capture controller.
package lowampa_capture_pkg;
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    POST    = 2'd1,
    FROZEN  = 2'd2,
    HOLDOFF = 2'd3
  } capture_state_t;
  localparam int CAPTURE_CNT_W = 16;
  localparam int DEF_NBEAMS    = 2;
  localparam int DEF_POST_BITS = 16;
  localparam int DEF_TS_BITS   = 32;
endpackage

// File: rtl/lowampa_trig_counter.sv
// lowampa_trig_counter: per-beam saturating accepted-trigger counters (used under LOWAMPA_CAPTURE_TRIGCOUNT_EN).
module lowampa_trig_counter
  import lowampa_capture_pkg::*;
#(
  parameter int NBEAMS = DEF_NBEAMS
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NBEAMS-1:0]               inc_i,
  output logic [NBEAMS*CAPTURE_CNT_W-1:0] count_o
);
  for (genvar i = 0; i < NBEAMS; i++) begin : g_cnt
    logic [CAPTURE_CNT_W-1:0] cnt_q;
    always_ff @(posedge clk or posedge rst)
      if (rst) cnt_q <= '0;
      else if (inc_i[i] && !(&cnt_q)) cnt_q <= cnt_q + CAPTURE_CNT_W'(1);
    assign count_o[i*CAPTURE_CNT_W +: CAPTURE_CNT_W] = cnt_q;
  end
endmodule

// File: rtl/lowampa_capture_ctrl.sv
// lowampa_capture_ctrl: trigger-to-capture FSM with timestamped trigger records.
// Define LOWAMPA_CAPTURE_TRIGCOUNT_EN to add per-beam trigger counters on trig_count_o.
module lowampa_capture_ctrl
  import lowampa_capture_pkg::*;
#(
  parameter int NBEAMS    = DEF_NBEAMS,
  parameter int POST_BITS = DEF_POST_BITS,
  parameter int TS_BITS   = DEF_TS_BITS
) (
  input  logic                 aclk,
  input  logic                 aclk_rst,
  input  logic [NBEAMS-1:0]    trig_i,
  input  logic [NBEAMS-1:0]    trig_mask_i,
  input  logic                 force_i,
  input  logic [POST_BITS-1:0] posttrig_i,
  input  logic [POST_BITS-1:0] holdoff_i,
  input  logic                 auto_rearm_i,
  input  logic                 arm_i,
  input  logic                 capture_waiting,
  output logic                 capture_enable,
  output logic                 trig_valid_o,
  output logic [NBEAMS-1:0]    trig_beams_o,
  output logic                 trig_forced_o,
  output logic [TS_BITS-1:0]   trig_time_o,
  output logic [1:0]           state_o
`ifdef LOWAMPA_CAPTURE_TRIGCOUNT_EN
  ,
  output logic [NBEAMS*CAPTURE_CNT_W-1:0] trig_count_o
`endif
);
  capture_state_t state_q, state_d;
  logic [POST_BITS-1:0] cnt_q, cnt_d;
  logic [TS_BITS-1:0] ts_q, time_q, time_d;
  logic [NBEAMS-1:0] beams_q, beams_d, act;
  logic valid_q, valid_d, forced_q, forced_d, cap_en_q, cap_en_d, hit;
  always_comb begin
    act      = trig_i & trig_mask_i;
    hit      = (|act) | force_i;
    state_d  = state_q;
    cnt_d    = cnt_q;
    valid_d  = 1'b0;
    beams_d  = beams_q;
    forced_d = forced_q;
    time_d   = time_q;
    case (state_q)
      RUN: if (hit) begin
        state_d  = POST;
        cnt_d    = posttrig_i;
        valid_d  = 1'b1;
        beams_d  = act;
        forced_d = force_i;
        time_d   = ts_q;
      end
      POST: begin
        cnt_d   = (cnt_q == '0) ? '0 : cnt_q - POST_BITS'(1);
        state_d = (cnt_q == '0) ? FROZEN : POST;
      end
      FROZEN: if (capture_waiting && (auto_rearm_i || arm_i)) begin
        state_d = HOLDOFF;
        cnt_d   = holdoff_i;
      end
      default: begin
        cnt_d   = (cnt_q == '0) ? '0 : cnt_q - POST_BITS'(1);
        state_d = (cnt_q == '0) ? RUN : HOLDOFF;
      end
    endcase
    // registered so capture_enable never glitches on decode
    cap_en_d = (state_d != FROZEN);
  end
  always_ff @(posedge aclk or posedge aclk_rst)
    if (aclk_rst) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      beams_q  <= '0;
      forced_q <= 1'b0;
      time_q   <= '0;
      cap_en_q <= 1'b1;
      ts_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      beams_q  <= beams_d;
      forced_q <= forced_d;
      time_q   <= time_d;
      cap_en_q <= cap_en_d;
      ts_q     <= ts_q + TS_BITS'(1);
    end
  assign capture_enable = cap_en_q;
  assign trig_valid_o   = valid_q;
  assign trig_beams_o   = beams_q;
  assign trig_forced_o  = forced_q;
  assign trig_time_o    = time_q;
  assign state_o        = state_q;
`ifdef LOWAMPA_CAPTURE_TRIGCOUNT_EN
  lowampa_trig_counter #(.NBEAMS(NBEAMS)) u_cnt (
    .clk    (aclk),
    .rst    (aclk_rst),
    .inc_i  (valid_q ? beams_q : '0),
    .count_o(trig_count_o)
  );
`endif
endmodule

// File: tb/tb_lowampa_capture_ctrl.sv
// tb_lowampa_capture_ctrl: directed scoreboard bench for lowampa_capture_ctrl.
module tb_lowampa_capture_ctrl;
  typedef struct packed {
    logic [1:0]  beams;
    logic        forced;
    logic [31:0] ts;
  } rec_t;
  logic aclk = 1'b0, aclk_rst = 1'b1;
  logic [1:0] trig = '0, mask = 2'b11;
  logic force_ = 1'b0, auto_rearm = 1'b0, arm = 1'b0, waiting = 1'b0;
  logic [15:0] posttrig = 16'd4, holdoff = '0;
  logic capture_enable, trig_valid, trig_forced;
  logic [1:0] trig_beams, state;
  logic [31:0] trig_time;
`ifdef LOWAMPA_CAPTURE_TRIGCOUNT_EN
  logic [31:0] trig_count;
`endif
  rec_t exp_q[$];
  int checks = 0, failures = 0;
  int unsigned tb_ts;
  lowampa_capture_ctrl dut (
    .aclk(aclk), .aclk_rst(aclk_rst), .trig_i(trig), .trig_mask_i(mask), .force_i(force_),
    .posttrig_i(posttrig), .holdoff_i(holdoff), .auto_rearm_i(auto_rearm), .arm_i(arm),
    .capture_waiting(waiting), .capture_enable(capture_enable), .trig_valid_o(trig_valid),
    .trig_beams_o(trig_beams), .trig_forced_o(trig_forced), .trig_time_o(trig_time),
    .state_o(state)
`ifdef LOWAMPA_CAPTURE_TRIGCOUNT_EN
    , .trig_count_o(trig_count)
`endif
  );
  always #5 aclk = ~aclk;
  always @(posedge aclk or posedge aclk_rst)
    if (aclk_rst) tb_ts <= 0;
    else tb_ts <= tb_ts + 1;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s at ts=%0d: got %0h expected %0h", name, tb_ts, got, want);
    end
  endtask
  task automatic step();
    @(posedge aclk);
    #1;
  endtask
  task automatic go(input int unsigned n);
    int guard = 0;
    while (tb_ts != n && guard < 1000) begin
      step();
      guard++;
    end
    if (tb_ts != n) begin
      failures++;
      $display("FAIL goto: got ts %0d expected %0d", tb_ts, n);
    end
  endtask
  always @(negedge aclk)
    if (!aclk_rst && trig_valid) begin
      if (exp_q.size() == 0) chk("unexpected_record", {trig_beams, trig_forced, trig_time}, 64'hdead);
      else begin
        rec_t e;
        e = exp_q.pop_front();
        chk("record", {trig_beams, trig_forced, trig_time}, {e.beams, e.forced, e.ts});
      end
    end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge aclk);
    #1 aclk_rst = 1'b0;
    chk("rst_state", state, 0);
    chk("rst_cap_en", capture_enable, 1);
    chk("rst_valid", trig_valid, 0);
    chk("rst_beams", trig_beams, 0);
    chk("rst_forced", trig_forced, 0);
    chk("rst_time", trig_time, 0);
    go(10); trig = 2'b01; exp_q.push_back('{2'b01, 1'b0, 32'd10}); step(); trig = '0;
    chk("post_state", state, 1);
    chk("post_cap_en", capture_enable, 1);
    go(12); chk("time_hold", trig_time, 10);
    go(15); chk("cap_en_last_post", capture_enable, 1);
    go(16); chk("cap_en_frozen", capture_enable, 0); chk("frozen_state", state, 2);
    go(18); arm = 1'b1; step(); arm = 1'b0; trig = 2'b01; step(); trig = '0;
    chk("arm_no_wait_state", state, 2);
    chk("arm_no_wait_cap", capture_enable, 0);
    chk("frozen_beams_hold", trig_beams, 2'b01);
    chk("frozen_time_hold", trig_time, 10);
    go(22); waiting = 1'b1; arm = 1'b1; holdoff = 16'd3; step(); waiting = 1'b0; arm = 1'b0;
    chk("holdoff_state", state, 3);
    chk("holdoff_cap_en", capture_enable, 1);
    go(26); trig = 2'b01; step(); trig = 2'b10; exp_q.push_back('{2'b10, 1'b0, 32'd27}); step(); trig = '0;
    chk("rearm_post_state", state, 1);
    go(33); chk("rearm_frozen_cap", capture_enable, 0);
    holdoff = '0; waiting = 1'b1; arm = 1'b1; step(); waiting = 1'b0; arm = 1'b0;
    go(35); chk("run_again", state, 0);
    mask = 2'b10; trig = 2'b01; step(); step();
    chk("masked_state", state, 0);
    chk("masked_cap_en", capture_enable, 1);
    trig = '0; mask = 2'b11;
    go(38); force_ = 1'b1; trig = 2'b11; exp_q.push_back('{2'b11, 1'b1, 32'd38}); step(); force_ = 1'b0; trig = '0;
    go(44); chk("force_frozen", state, 2);
    auto_rearm = 1'b1; waiting = 1'b1;
    go(46); chk("auto_run", state, 0);
    posttrig = '0; mask = 2'b00;
    go(47); force_ = 1'b1; exp_q.push_back('{2'b00, 1'b1, 32'd47}); step(); force_ = 1'b0;
    chk("p0_cap_n1", capture_enable, 1);
    go(49); chk("p0_cap_n2", capture_enable, 0);
    go(50); chk("p0_cap_n3", capture_enable, 1); chk("p0_state_n3", state, 3);
    go(51); chk("p0_state_n4", state, 0);
    mask = 2'b11; trig = 2'b01; exp_q.push_back('{2'b01, 1'b0, 32'd51}); step(); trig = '0;
    chk("p0b_cap_n1", capture_enable, 1);
    go(53); chk("p0b_cap_n2", capture_enable, 0);
    go(54); chk("p0b_cap_n3", capture_enable, 1);
    go(55); chk("p0b_state_n4", state, 0);
    auto_rearm = 1'b0; waiting = 1'b0; posttrig = 16'd4;
    go(56); trig = 2'b10; exp_q.push_back('{2'b10, 1'b0, 32'd56}); step(); trig = '0;
    go(58); chk("mid_post_state", state, 1);
`ifdef LOWAMPA_CAPTURE_TRIGCOUNT_EN
    chk("count_beam0", trig_count[15:0], 3);
    chk("count_beam1", trig_count[31:16], 3);
`endif
    #2 aclk_rst = 1'b1;
    #1;
    chk("async_rst_cap_en", capture_enable, 1);
    chk("async_rst_state", state, 0);
    chk("async_rst_beams", trig_beams, 0);
`ifdef LOWAMPA_CAPTURE_TRIGCOUNT_EN
    chk("async_rst_counts", trig_count, 0);
`endif
    @(posedge aclk); #1 aclk_rst = 1'b0;
    chk("post_rst_time", trig_time, 0);
    go(3); trig = 2'b01; exp_q.push_back('{2'b01, 1'b0, 32'd3}); step(); trig = '0;
    step(); step();
    chk("records_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lowampa_capture_ctrl.md
# lowampa_capture_ctrl

Trigger-to-capture controller sitting directly downstream of the low-amplitude trigger path. Consumes the per-beam trigger vector and the capture buffer's `capture_waiting` flag, and drives `capture_enable` so that buffers keep a programmable number of post-trigger cycles, freeze for readout, then re-arm after a holdoff. Each accepted trigger produces a latched record: beam mask, timestamp and force flag.

## Interface
Parameters:
- `NBEAMS`, 2: width of trigger vector.
- `POST_BITS`, 16: width of post-trigger and holdoff counters.
- `TS_BITS`, 32: timestamp width.

Ports:
- `aclk` in 1: sole clock; all logic is synchronous to it.
- `aclk_rst` in 1: asynchronous, active-high reset.
- `trig_i` in NBEAMS: per-beam trigger, level-sampled every cycle.
- `trig_mask_i` in NBEAMS: 1 = beam enabled.
- `force_i` in 1: single-cycle software trigger.
- `posttrig_i` in POST_BITS: post-trigger cycles; static while not in RUN.
- `holdoff_i` in POST_BITS: holdoff cycles after re-arm.
- `auto_rearm_i` in 1: 1 = re-arm without `arm_i`.
- `arm_i` in 1: single-cycle re-arm request.
- `capture_waiting` in 1: buffer readout done, awaiting re-enable.
- `capture_enable` out 1: buffers record while high.
- `trig_valid_o` out 1: one-cycle pulse; record valid.
- `trig_beams_o` out NBEAMS: masked beams active on the accepted cycle.
- `trig_forced_o` out 1: record includes a force.
- `trig_time_o` out TS_BITS: timestamp of the accepted cycle.
- `state_o` out 2: current state, for debug.
- `trig_count_o` out NBEAMS×16: per-beam accepted-trigger counts. Present only with `LOWAMPA_CAPTURE_TRIGCOUNT_EN`.

## Operation
- Free-running timestamp `ts`: reset 0, +1 per cycle, wraps mod 2^TS_BITS.
- `hit = |(trig_i & trig_mask_i) | force_i`.
- States:
  - `RUN`
    - `capture_enable=1`.
    - On `hit`: latch record (`trig_beams_o=trig_i&trig_mask_i`, `trig_forced_o=force_i`, `trig_time_o=ts`), pulse `trig_valid_o`, load `cnt=posttrig_i`, go `POST`.
  - `POST`
    - `capture_enable=1`; `cnt` decrements each cycle.
    - When `cnt==0`, go `FROZEN`.
    - If `posttrig_i==0`, `POST` lasts exactly one cycle.
  - `FROZEN`
    - `capture_enable=0`.
    - When `capture_waiting && (auto_rearm_i || arm_i)`: load `cnt=holdoff_i`, go `HOLDOFF`.
    - An `arm_i` arriving while `capture_waiting=0` is discarded; it is not remembered.
  - `HOLDOFF`
    - `capture_enable=1`; `cnt` decrements.
    - When `cnt==0`, go `RUN`.
- Outside `RUN`:
  - `hit` is ignored and no record is produced.
  - Record outputs hold their last value.
- Simultaneous beam trigger and `force_i`: one record, with beam bits set and `trig_forced_o=1`.
- A `force_i` with all beams masked still triggers.
- State encoding: `RUN`=0, `POST`=1, `FROZEN`=2, `HOLDOFF`=3.

## Timing
- Reset values:
  - state `RUN`, `capture_enable=1`, `trig_valid_o=0`.
  - `trig_beams_o=0`, `trig_forced_o=0`, `trig_time_o=0`, `ts=0`.
  - counts 0.
- `hit` at cycle N:
  - `trig_valid_o` high in cycle N+1.
  - `state_o=POST` from N+1.
  - `capture_enable` first low at cycle N+2+`posttrig_i`.
- Re-arm condition true at cycle M:
  - `HOLDOFF` from M+1.
  - `RUN` from M+2+`holdoff_i`.
  - Earliest next accepted `hit` is at M+2+`holdoff_i`.
- `capture_enable` is registered and glitch-free.
- Async reset mid-`POST` or mid-`FROZEN`: `capture_enable` returns to 1 immediately; any pending record is lost.

## Configuration
- `LOWAMPA_CAPTURE_TRIGCOUNT_EN` defined:
  - Per-beam 16-bit saturating counters, +1 for each beam bit in an accepted record.
  - Counters saturate at 0xFFFF and clear only on reset.
  - Exposed on `trig_count_o`.
- Not defined: counters and the `trig_count_o` port are absent; all other behaviour is identical.

## Structure
- Package `lowampa_capture_pkg`:
  - state enum `capture_state_t` (encoding above).
  - `CAPTURE_CNT_W=16`.
  - default widths.
- Sub-module `lowampa_trig_counter`: NBEAMS saturating counters, instantiated only under the macro.
- The state machine, timestamp and record latch live in the top module.

## Test plan
- Reset, then `posttrig_i=4`, `trig_i=2'b01` at cycle 10 with `ts=10`:
  - `trig_valid_o` at 11, `trig_time_o=10`, `trig_beams_o=01`.
  - `capture_enable` low from cycle 16.
- `trig_mask_i=2'b10`, `trig_i=2'b01` → no record; `capture_enable` stays 1.
- `force_i` and `trig_i=2'b11` in the same cycle with mask 11 → one record, beams 11, forced 1.
- In `FROZEN` with `auto_rearm_i=0`:
  - `arm_i` while `capture_waiting=0` → remains `FROZEN`.
  - `capture_waiting=1` plus `arm_i` at M with `holdoff_i=3` → `RUN` at M+5.
  - A trigger at M+4 is ignored; a trigger at M+5 is accepted.
- `posttrig_i=0` and `holdoff_i=0`, `auto_rearm_i=1`, `capture_waiting=1`: trigger at N → `capture_enable` low only in cycle N+2, back to `RUN` at N+4.
- Assert `aclk_rst` mid-`POST` → `capture_enable=1` asynchronously; with the macro, counters return to 0.
